// File: rtl/instr_pkg.sv
// Shared instruction-format constants and controller state type for the
// instruction-memory access path.
package instr_pkg;

  localparam int OPCODE_W  = 5;
  localparam int OPERAND_W = 12;
  localparam int INSTR_W   = OPCODE_W + OPERAND_W;

  localparam logic [OPCODE_W-1:0] OP_LOAD  = 5'd1;
  localparam logic [OPCODE_W-1:0] OP_STORE = 5'd2;
  localparam logic [OPCODE_W-1:0] OP_ADD   = 5'd3;
  localparam logic [OPCODE_W-1:0] OP_JMP   = 5'd16;
  localparam logic [OPCODE_W-1:0] OP_NOP   = 5'd28;
  localparam logic [OPCODE_W-1:0] OP_HALT  = 5'd31;

  // Returned to a core that fetched from a non-existent address.
  localparam logic [INSTR_W-1:0] NOP_INSTR = {OP_NOP, {OPERAND_W{1'b0}}};

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_LOAD
  } ctrl_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin priority picker: the search starts at ptr_i and wraps, so the
// first requesting index at or after the pointer wins.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  // Walk all N positions from the pointer and latch the first request seen.
  always_comb begin
    int pos;
    pos     = 0;
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int k = 0; k < N; k++) begin
      pos = int'(ptr_i) + k;
      if (pos >= N) pos = pos - N;
      if (!valid_o && req_i[pos]) begin
        valid_o    = 1'b1;
        gnt_o[pos] = 1'b1;
        idx_o      = IDX_W'(pos);
      end
    end
  end

endmodule

// File: rtl/imem_access_ctrl.sv
// Owner of the single instruction-memory port: round-robin core fetches in
// RUN, a one-cycle DRAIN to let the last read return, and LOAD where the host
// writes program words while the cores are locked out.
module imem_access_ctrl #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 12,
  parameter int INSTR_W   = instr_pkg::INSTR_W,
  parameter int MEM_DEPTH = 2048
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_CORES-1:0]        core_req,
  input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
  output logic [NUM_CORES-1:0]        core_gnt,
  output logic [NUM_CORES-1:0]        core_rvalid,
  output logic [INSTR_W-1:0]          core_rdata,
  input  logic                        ld_session,
  output logic                        ld_ready,
  input  logic                        ld_wr,
  input  logic [ADDR_W-1:0]           ld_addr,
  input  logic [INSTR_W-1:0]          ld_data,
  output logic                        ld_err,
  output logic                        mem_read_en,
  output logic                        mem_write_en,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [INSTR_W-1:0]          mem_wdata,
  input  logic [INSTR_W-1:0]          mem_rdata
);
  import instr_pkg::*;

  localparam int IDX_W = $clog2(NUM_CORES);
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(MEM_DEPTH);

  ctrl_state_e        state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               tag_valid_q, tag_valid_d;
  logic [IDX_W-1:0]   tag_idx_q, tag_idx_d;
  logic               tag_oor_q, tag_oor_d;
  logic [INSTR_W-1:0] rdata_q, rdata_d;

  logic [ADDR_W-1:0]    addr_arr [NUM_CORES];
  logic [NUM_CORES-1:0] arb_gnt;
  logic [IDX_W-1:0]     arb_idx;
  logic                 arb_valid;
  logic                 read_oor;
  logic                 ld_oor;

  // Split the flat address bus into one address per core.
  always_comb begin
    for (int i = 0; i < NUM_CORES; i++) begin
      addr_arr[i] = core_addr[i*ADDR_W +: ADDR_W];
    end
  end

  rr_arbiter #(
    .N     (NUM_CORES),
    .IDX_W (IDX_W)
  ) u_arb (
    .req_i   (core_req),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  // Mode sequencing plus the memory-port mux; everything is held at zero while
  // rst_n is low so a requesting core sees no grant during reset.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    tag_valid_d  = 1'b0;
    tag_idx_d    = '0;
    tag_oor_d    = 1'b0;
    core_gnt     = '0;
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    ld_ready     = 1'b0;
    ld_err       = 1'b0;
    read_oor     = ({1'b0, addr_arr[arb_idx]} >= DEPTH_LIM);
    ld_oor       = ({1'b0, ld_addr} >= DEPTH_LIM);
    if (rst_n) begin
      unique case (state_q)
        ST_RUN: begin
          if (ld_session) begin
            state_d = ST_DRAIN;
          end else if (arb_valid) begin
            core_gnt    = arb_gnt;
            mem_read_en = 1'b1;
            mem_addr    = addr_arr[arb_idx];
            rr_ptr_d    = (arb_idx == IDX_W'(NUM_CORES-1)) ? '0 : arb_idx + IDX_W'(1);
            tag_valid_d = 1'b1;
            tag_idx_d   = arb_idx;
            tag_oor_d   = read_oor;
          end
        end
        ST_DRAIN: state_d = ld_session ? ST_LOAD : ST_RUN;
        ST_LOAD: begin
          ld_ready = 1'b1;
          if (!ld_session) state_d = ST_RUN;
        end
        default: state_d = ST_RUN;
      endcase
      if (ld_wr) begin
        if (state_q == ST_LOAD && !ld_oor) begin
          mem_write_en = 1'b1;
          mem_addr     = ld_addr;
          mem_wdata    = ld_data;
        end else begin
          ld_err = 1'b1;
        end
      end
    end
  end

  // Deliver the fetch granted last cycle; otherwise keep showing the last word.
  always_comb begin
    core_rvalid = '0;
    core_rdata  = rdata_q;
    if (tag_valid_q) begin
      core_rvalid[tag_idx_q] = 1'b1;
      core_rdata             = tag_oor_q ? NOP_INSTR : mem_rdata;
    end
    rdata_d = core_rdata;
  end

  // State, pointer and read-tag registers; reset drops any read in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      rr_ptr_q    <= '0;
      tag_valid_q <= 1'b0;
      tag_idx_q   <= '0;
      tag_oor_q   <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      tag_valid_q <= tag_valid_d;
      tag_idx_q   <= tag_idx_d;
      tag_oor_q   <= tag_oor_d;
      rdata_q     <= rdata_d;
    end
  end

endmodule
